// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the multiply/divide unit: drives Multop/aluSel
// from E, mirrors unit occupancy, stalls D for MD-class ops, keeps statistics.
module md_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_op,
  input  logic        e_valid,
  input  logic [4:0]  e_op,
  input  logic        e_flush,
  input  logic        md_busy,
  output logic [4:0]  md_op,
  output logic        md_sel,
  output logic        stall_d,
  output logic        err,
  output logic [31:0] op_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] LAT_MULT = 4'd5;
  localparam logic [3:0] LAT_DIV  = 4'd10;
  localparam logic [4:0] OP_NOP   = 5'd31;

  logic [0:0] state;
  logic [3:0] remaining;

  logic is_busy;
  logic e_live;
  logic e_invalid;
  logic start_issue;
  logic err_set;

  // Any MD-class op in D stalls, so the op code itself is not needed here.
  logic unused_d_op;
  assign unused_d_op = ^d_op;

  assign is_busy     = (state == BUSY);
  assign e_live      = e_valid & ~e_flush;
  assign e_invalid   = e_live & (e_op >= 5'd8) & (e_op <= 5'd30);

  assign md_sel      = e_live & ~is_busy & (e_op <= 5'd7);
  assign md_op       = e_valid ? e_op : OP_NOP;
  assign start_issue = md_sel & (e_op <= 5'd3);
  assign stall_d     = d_valid & (is_busy | start_issue);

  // Mirror mismatch, an MD op reaching E while busy, or an undefined op code.
  assign err_set     = (md_busy != is_busy) | (e_live & is_busy) | e_invalid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 4'd0;
      err       <= 1'b0;
      op_cnt    <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (is_busy) begin
        remaining <= remaining - 4'd1;
        if (remaining == 4'd1) state <= IDLE;
      end else if (start_issue) begin
        state     <= BUSY;
        remaining <= (e_op <= 5'd1) ? LAT_MULT : LAT_DIV;
      end

      if (err_set)     err       <= 1'b1;
      if (start_issue) op_cnt    <= op_cnt + 32'd1;
      if (stall_d)     stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios then random traffic,
// compared against a cycle-indexed occupancy model of the MD unit.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_op;
  logic        e_valid;
  logic [4:0]  e_op;
  logic        e_flush;
  logic        md_busy;
  logic [4:0]  md_op;
  logic        md_sel;
  logic        stall_d;
  logic        err;
  logic [31:0] op_cnt;
  logic [31:0] stall_cnt;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_op(d_op),
    .e_valid(e_valid), .e_op(e_op), .e_flush(e_flush),
    .md_busy(md_busy),
    .md_op(md_op), .md_sel(md_sel), .stall_d(stall_d),
    .err(err), .op_cnt(op_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the unit is busy in cycle c when c <= busy_end.
  longint      cyc      = 0;
  longint      busy_end = -1;
  logic        m_err    = 1'b0;
  logic [31:0] m_opc    = 32'd0;
  logic [31:0] m_stc    = 32'd0;

  function automatic logic m_busy();
    return cyc <= busy_end;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One pipeline cycle: drive inputs, check outputs, take the edge, update model.
  task automatic step(input logic rst, input logic dv, input logic [4:0] dop,
                      input logic ev, input logic [4:0] eop, input logic ef,
                      input logic flip);
    logic mb, x_sel, x_start, x_stall;
    reset   = rst;
    d_valid = dv;  d_op = dop;
    e_valid = ev;  e_op = eop;  e_flush = ef;
    mb      = m_busy() ^ flip;
    md_busy = mb;
    #1;
    x_sel   = ev && !ef && !m_busy() && (eop < 8);
    x_start = x_sel && (eop < 4);
    x_stall = dv && (m_busy() || x_start);
    check("md_sel",    {31'd0, md_sel},  {31'd0, x_sel});
    check("md_op",     {27'd0, md_op},   {27'd0, ev ? eop : 5'd31});
    check("stall_d",   {31'd0, stall_d}, {31'd0, x_stall});
    check("err",       {31'd0, err},     {31'd0, m_err});
    check("op_cnt",    op_cnt,           m_opc);
    check("stall_cnt", stall_cnt,        m_stc);
    @(posedge clk);
    if (rst) begin
      m_err = 1'b0; m_opc = 32'd0; m_stc = 32'd0; busy_end = cyc;
    end else begin
      if (mb != m_busy())                              m_err = 1'b1;
      if (ev && !ef && m_busy())                       m_err = 1'b1;
      if (ev && !ef && eop >= 8 && eop <= 30)          m_err = 1'b1;
      if (x_start) begin
        m_opc++;
        busy_end = cyc + ((eop < 2) ? 5 : 10);
      end
      if (x_stall) m_stc++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; d_valid = 0; d_op = 0; e_valid = 0; e_op = 0; e_flush = 0; md_busy = 0;
    #1;

    // Reset, then mult in E at cycle 2; mfhi in D exposes the busy window.
    do_reset(); do_reset();
    step(0, 0, 0, 1, 5'd0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 5'd4, 0, 0, 0, 0);
    check("mult_opcnt", op_cnt, 32'd1);
    check("mult_stallcnt", stall_cnt, 32'd5);
    check("mult_err", {31'd0, err}, 32'd0);

    // div with mfhi held in D: 11 stall cycles, mfhi enters E at T+11.
    do_reset();
    step(0, 1, 5'd4, 1, 5'd2, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 5'd4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd4, 0, 0);
    check("div_stallcnt", stall_cnt, 32'd11);

    // Flushed mult neither issues nor stalls a D-stage mflo.
    do_reset();
    step(0, 1, 5'd5, 1, 5'd0, 1, 0);
    step(0, 1, 5'd5, 0, 0, 0, 0);
    check("flush_opcnt", op_cnt, 32'd0);
    check("flush_stallcnt", stall_cnt, 32'd0);

    // md_busy falls one cycle early on a multu: err becomes sticky.
    do_reset();
    step(0, 0, 0, 1, 5'd1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(4);
    check("early_err", {31'd0, err}, 32'd1);
    do_reset();
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_opcnt", op_cnt, 32'd0);

    // mthi in E with mult in D: no stall, then the mult issues.
    step(0, 1, 5'd0, 1, 5'd6, 0, 0);
    step(0, 0, 0, 1, 5'd0, 0, 0);
    idle(6);
    check("mthi_opcnt", op_cnt, 32'd1);

    // Invalid op code in E.
    step(0, 0, 0, 1, 5'd17, 0, 0);
    check("inv_err", {31'd0, err}, 32'd1);
    do_reset();

    // op_cnt wrap from all-ones.
    force dut.op_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.op_cnt;
    m_opc = 32'hFFFF_FFFF;
    step(0, 0, 0, 1, 5'd0, 0, 0);
    check("wrap_opcnt", op_cnt, 32'd0);
    idle(6);

    // Mid-operation reset: no err afterwards.
    step(0, 0, 0, 1, 5'd3, 0, 0);
    idle(3);
    do_reset();
    idle(2);
    check("midrst_err", {31'd0, err}, 32'd0);

    // Random traffic with a compliant md_busy and occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic ev;
      logic [4:0] eop;
      int sel;
      sel = $urandom_range(0, 19);
      eop = (sel == 0) ? 5'($urandom_range(8, 30)) :
            (sel == 1) ? 5'd31 : 5'($urandom_range(0, 7));
      ev  = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), ev, eop, $urandom_range(0, 7) == 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller on the pipeline side of the multiply/divide unit: it drives that unit's Multop/aluSel inputs from the E stage and tracks the unit's occupancy with its own latency mirror. It generates the D-stage stall for MD-class instructions and cross-checks its mirror against the unit's busy output. It also keeps issue and stall statistics. It sits between the E-stage pipeline register and the MD unit, alongside the main hazard unit.

## Interface
- No parameters. Latencies are fixed: mult/multu = 5, div/divu = 10.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- d_valid  in  1  D-stage instruction is MD-class (op codes 0–7)
- d_op  in  5  D-stage MD op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo
- e_valid  in  1  E-stage instruction is MD-class
- e_op  in  5  E-stage MD op code, same encoding as d_op
- e_flush  in  1  E-stage instruction is killed this cycle
- md_busy  in  1  busy output of the MD unit
- md_op  out  5  Multop to the MD unit
- md_sel  out  1  aluSel to the MD unit
- stall_d  out  1  freeze PC/F/D and bubble E
- err  out  1  sticky protocol/mirror error
- op_cnt  out  32  count of issued mult/multu/div/divu
- stall_cnt  out  32  count of cycles with stall_d=1

## Operation
- States:
  - IDLE: the unit is free.
  - BUSY: an operation is in flight. A 4-bit `remaining` register counts the cycles left.
- Issue (combinational):
  - md_sel = e_valid & ~e_flush & (state==IDLE) & (e_op<=7).
  - md_op = e_op when e_valid, else 5'd31. Code 31 is a no-op and makes the unit output 0.
  - mfhi/mflo read through md_op even when md_sel=0.
- start_issue = md_sel & (e_op<=3).
- Transitions:
  - IDLE -> BUSY on start_issue. remaining loads 5 (e_op 0/1) or 10 (e_op 2/3).
  - In BUSY, remaining decrements each cycle.
  - BUSY -> IDLE at the edge where remaining==1.
  - Ops 4–7 issue without leaving IDLE.
- Stall: stall_d = d_valid & ((state==BUSY) | start_issue).
  - Any MD-class op in D waits while the unit is busy, or while an op is starting in E.
  - Non-MD instructions never stall here.
- Flush:
  - e_flush suppresses md_sel and start_issue in the same cycle.
  - e_flush never aborts an operation already in BUSY.
- err is set at the clock edge on either condition, and is cleared only by reset:
  - Mirror mismatch: md_busy != (state==BUSY).
  - Violation: e_valid & ~e_flush & (state==BUSY). An MD op reached E during busy; md_sel stays 0.
- Counters:
  - op_cnt += 1 on each start_issue.
  - stall_cnt += 1 on each cycle with stall_d=1.
  - Both wrap modulo 2^32.
  - A simultaneous increment and reset resolves to 0.
- Codes 8–30 in e_op are treated as invalid: md_sel=0 and err is set.

## Timing
- Reset values:
  - state=IDLE, remaining=0, err=0, op_cnt=0, stall_cnt=0.
  - md_sel=0 while e_valid=0; md_op=31 while e_valid=0; stall_d=0 while d_valid=0.
- Issue cycle T (start_issue=1):
  - The unit samples A/B at edge T.
  - state=BUSY during cycles T+1 … T+L, with L = 5 or 10.
  - Back to IDLE in cycle T+L+1, the same edge at which the unit writes Hi/Lo.
- A dependent mfhi in D at cycle T stalls during cycles T through T+L.
- That mfhi enters E in cycle T+L+1 and reads the updated Hi.
- Back-to-back: a second mult in D at T enters E at T+L+1 and issues there with no extra gap.
- Mid-operation reset: state returns to IDLE at the next edge. The unit resets on the same edge, so no err is raised.
- All outputs except the counters and err are glitch-free functions of registered state and the current inputs. There are no combinational paths from md_busy.

## Test plan
- Reset, then mult in E (e_op=0, e_valid=1) at cycle 2:
  - md_sel=1 in cycle 2.
  - State is BUSY in cycles 3–7 and IDLE in cycle 8.
  - op_cnt=1, err=0 with a compliant md_busy model.
- div issued at T with mfhi held in D:
  - stall_d=1 in cycles T…T+10 (11 cycles), 0 in cycle T+11.
  - stall_cnt=11.
- mult in E with e_flush=1:
  - md_sel=0, state stays IDLE, op_cnt=0.
  - A D-stage mflo is not stalled.
- Model md_busy falling one cycle early on a multu:
  - err=1 from the next edge and stays 1 until reset.
  - Then assert reset: err=0, op_cnt=0.
- mthi in E (e_op=6) with mult in D:
  - md_sel=1, state stays IDLE, stall_d=0.
  - Next cycle the mult issues normally.
- Preload op_cnt to 32'hFFFFFFFF via a forced issue sequence, then one mult: op_cnt wraps to 0.
